// File: rtl/context_ctrl_pkg.sv
// Shared types and constants for the process context-switch controller.
package context_ctrl_pkg;

    localparam int ADDR_W = 10;

    typedef enum logic [2:0] {
        OS_RUN,
        RESTORE,
        PROC_RUN,
        SAVE,
        RETURN
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_QUANTUM = 2'd1;
    localparam logic [1:0] CAUSE_SYSCALL = 2'd2;
    localparam logic [1:0] CAUSE_END     = 2'd3;

endpackage

// File: rtl/context_ctrl_ctx_table.sv
// Saved-PC register file: one write port, one combinational read port,
// synchronous reset of every entry to zero.
module ctx_table #(
    parameter int NPROC  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(NPROC)-1:0] wr_slot,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [$clog2(NPROC)-1:0] rd_slot,
    output logic [ADDR_W-1:0]        rd_addr
);

    logic [ADDR_W-1:0] mem [NPROC];

    // NOTE: this table is small and must read as 0 after reset, so every entry
    // is cleared; large RAM-style storage is normally left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPROC; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_slot] <= wr_addr;
        end
    end

    assign rd_addr = mem[rd_slot];

endmodule

// File: rtl/context_ctrl.sv
// Scheduling-side controller that switches the PC block between the OS and
// process contexts, restoring and saving per-slot process PCs.
module context_ctrl #(
    parameter int NPROC   = 4,
    parameter int QUANTUM = 16,
    parameter int ADDR_W  = context_ctrl_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [$clog2(NPROC)-1:0] load_slot,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic                     os_dispatch,
    input  logic [$clog2(NPROC)-1:0] disp_slot,
    input  logic                     syscall,
    input  logic                     proc_end,
    input  logic [ADDR_W-1:0]        proc_pc,
    output logic                     proc_num,
    output logic                     hlt,
    output logic                     pc_ovr_en,
    output logic [ADDR_W-1:0]        pc_ovr_addr,
    output logic [$clog2(NPROC)-1:0] cur_slot,
    output logic [1:0]               cause,
    output logic                     irq_os,
    output logic [NPROC-1:0]         slot_valid
);

    import context_ctrl_pkg::*;

    localparam int                SLOT_W = $clog2(NPROC);
    localparam int                CNT_W  = $clog2(QUANTUM);
    localparam logic [CNT_W-1:0]  QMAX   = CNT_W'(QUANTUM - 1);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               busy, load_ok, disp_ok, trap_exit;

    // A load arriving during SAVE is parked here because SAVE owns the write port.
    logic               pend_vld;
    logic [SLOT_W-1:0]  pend_slot;
    logic [ADDR_W-1:0]  pend_addr;
    logic               pend_take, pend_clr;

    logic               wr_en;
    logic [SLOT_W-1:0]  wr_slot;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  tbl_rd;

    assign busy      = (state == RESTORE) || (state == PROC_RUN) || (state == SAVE);
    assign load_ok   = load_en && !(busy && (load_slot == cur_slot));
    assign disp_ok   = slot_valid[disp_slot] || (load_ok && (load_slot == disp_slot));
    assign trap_exit = proc_end || syscall || (cnt == '0);

    // NOTE: combinational blocks assign every output a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        proc_num   = 1'b0;
        hlt        = 1'b0;
        pc_ovr_en  = 1'b0;
        irq_os     = 1'b0;
        case (state)
            OS_RUN: begin
                if (os_dispatch && disp_ok) state_next = RESTORE;
            end
            RESTORE: begin
                proc_num   = 1'b1;
                pc_ovr_en  = 1'b1;
                state_next = PROC_RUN;
            end
            PROC_RUN: begin
                proc_num = 1'b1;
                if (trap_exit) state_next = SAVE;
            end
            SAVE: begin
                proc_num   = 1'b1;
                hlt        = 1'b1;
                state_next = RETURN;
            end
            RETURN: begin
                irq_os     = 1'b1;
                state_next = OS_RUN;
            end
            default: state_next = OS_RUN;
        endcase
    end

    // Write-port arbitration: SAVE first, then a parked load, then a fresh load.
    always_comb begin
        wr_en     = 1'b0;
        wr_slot   = load_slot;
        wr_addr   = load_addr;
        pend_take = 1'b0;
        pend_clr  = 1'b0;
        if (state == SAVE) begin
            wr_en     = 1'b1;
            wr_slot   = cur_slot;
            wr_addr   = proc_pc;
            pend_take = load_ok;
            pend_clr  = pend_vld && (pend_slot == cur_slot);
        end else if (pend_vld) begin
            wr_en    = 1'b1;
            pend_clr = 1'b1;
            if (load_ok && (load_slot == pend_slot)) begin
                wr_slot = load_slot;
                wr_addr = load_addr;
            end else begin
                wr_slot   = pend_slot;
                wr_addr   = pend_addr;
                pend_take = load_ok;
            end
        end else if (load_ok) begin
            wr_en = 1'b1;
        end
    end

    ctx_table #(
        .NPROC  (NPROC),
        .ADDR_W (ADDR_W)
    ) u_ctx_table (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_slot (wr_slot),
        .wr_addr (wr_addr),
        .rd_slot (cur_slot),
        .rd_addr (tbl_rd)
    );

    always_comb begin
        pc_ovr_addr = '0;
        if (pc_ovr_en) begin
            pc_ovr_addr = (pend_vld && (pend_slot == cur_slot)) ? pend_addr : tbl_rd;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= OS_RUN;
            cnt        <= '0;
            cur_slot   <= '0;
            cause      <= CAUSE_NONE;
            slot_valid <= '0;
            pend_vld   <= 1'b0;
            pend_slot  <= '0;
            pend_addr  <= '0;
        end else begin
            state <= state_next;

            if (state == OS_RUN && os_dispatch && disp_ok) begin
                cur_slot <= disp_slot;
                cause    <= CAUSE_NONE;
            end

            if (state == RESTORE) begin
                cnt <= QMAX;
            end else if (state == PROC_RUN && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (state == PROC_RUN) begin
                if (proc_end)       cause <= CAUSE_END;
                else if (syscall)   cause <= CAUSE_SYSCALL;
                else if (cnt == '0) cause <= CAUSE_QUANTUM;
            end

            if (load_ok) slot_valid[load_slot] <= 1'b1;
            if (state == SAVE && cause == CAUSE_END) slot_valid[cur_slot] <= 1'b0;

            if (pend_take) begin
                pend_vld  <= 1'b1;
                pend_slot <= load_slot;
                pend_addr <= load_addr;
            end else if (pend_clr) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_context_ctrl.sv
// Directed self-checking bench for context_ctrl: dispatch, quantum, traps,
// load arbitration and reset during SAVE.
module tb_context_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic [1:0] load_slot;
    logic [9:0] load_addr;
    logic       os_dispatch;
    logic [1:0] disp_slot;
    logic       syscall;
    logic       proc_end;
    logic [9:0] proc_pc;
    logic       proc_num, hlt, pc_ovr_en, irq_os;
    logic [9:0] pc_ovr_addr;
    logic [1:0] cur_slot;
    logic [1:0] cause;
    logic [3:0] slot_valid;

    int tests = 0;
    int fails = 0;

    context_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_slot   (load_slot),
        .load_addr   (load_addr),
        .os_dispatch (os_dispatch),
        .disp_slot   (disp_slot),
        .syscall     (syscall),
        .proc_end    (proc_end),
        .proc_pc     (proc_pc),
        .proc_num    (proc_num),
        .hlt         (hlt),
        .pc_ovr_en   (pc_ovr_en),
        .pc_ovr_addr (pc_ovr_addr),
        .cur_slot    (cur_slot),
        .cause       (cause),
        .irq_os      (irq_os),
        .slot_valid  (slot_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_proc_num"},  {31'd0, proc_num},  32'd0);
        check({tag, "_hlt"},       {31'd0, hlt},       32'd0);
        check({tag, "_pc_ovr_en"}, {31'd0, pc_ovr_en}, 32'd0);
        check({tag, "_irq_os"},    {31'd0, irq_os},    32'd0);
    endtask

    initial begin
        logic run_ok;
        reset = 1'b1; load_en = 1'b0; load_slot = '0; load_addr = '0;
        os_dispatch = 1'b0; disp_slot = '0; syscall = 1'b0; proc_end = 1'b0; proc_pc = '0;
        tick(); tick();
        reset = 1'b0;
        check_idle("rst");
        check("rst_ovr_addr", {22'd0, pc_ovr_addr}, 32'h0);
        check("rst_cur_slot", {30'd0, cur_slot}, 32'd0);
        check("rst_cause", {30'd0, cause}, 32'd0);
        check("rst_valid", {28'd0, slot_valid}, 32'h0);

        // Load slot 1 = 0x040, dispatch it, run a full quantum.
        load_en = 1'b1; load_slot = 2'd1; load_addr = 10'h040;
        tick();
        load_en = 1'b0;
        check("load1_valid", {28'd0, slot_valid}, 32'h2);
        os_dispatch = 1'b1; disp_slot = 2'd1;
        tick();
        os_dispatch = 1'b0;
        check("restore1_proc_num", {31'd0, proc_num}, 32'd1);
        check("restore1_ovr_en", {31'd0, pc_ovr_en}, 32'd1);
        check("restore1_ovr_addr", {22'd0, pc_ovr_addr}, 32'h040);
        check("restore1_cur_slot", {30'd0, cur_slot}, 32'd1);
        run_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!(proc_num === 1'b1 && hlt === 1'b0 && pc_ovr_en === 1'b0 && irq_os === 1'b0))
                run_ok = 1'b0;
        end
        check("quantum_16_cycles_run", {31'd0, run_ok}, 32'd1);
        proc_pc = 10'h2A5;
        tick();
        check("save1_hlt", {31'd0, hlt}, 32'd1);
        check("save1_cause", {30'd0, cause}, 32'd1);
        tick();
        check("ret1_irq", {31'd0, irq_os}, 32'd1);
        check("ret1_proc_num", {31'd0, proc_num}, 32'd0);
        tick();
        check_idle("os1");

        // Dispatch to an invalid slot is ignored.
        os_dispatch = 1'b1; disp_slot = 2'd2;
        tick();
        os_dispatch = 1'b0;
        check_idle("bad_disp");
        check("bad_disp_cur_slot", {30'd0, cur_slot}, 32'd1);
        tick();
        check_idle("bad_disp2");

        // Redispatch slot 1: restores the PC saved at quantum expiry.
        os_dispatch = 1'b1; disp_slot = 2'd1;
        tick();
        os_dispatch = 1'b0;
        check("restore2_ovr_addr", {22'd0, pc_ovr_addr}, 32'h2A5);
        check("restore2_cause_clr", {30'd0, cause}, 32'd0);
        tick(); tick(); tick();
        syscall = 1'b1; proc_pc = 10'h123;
        tick();
        syscall = 1'b0;
        check("save2_hlt", {31'd0, hlt}, 32'd1);
        check("save2_cause", {30'd0, cause}, 32'd2);
        tick();
        check("ret2_irq", {31'd0, irq_os}, 32'd1);
        tick();

        // Redispatch: restores 0x123; loads during PROC_RUN; end+syscall at counter 0.
        os_dispatch = 1'b1; disp_slot = 2'd1;
        tick();
        os_dispatch = 1'b0;
        check("restore3_ovr_addr", {22'd0, pc_ovr_addr}, 32'h123);
        tick(); tick();
        load_en = 1'b1; load_slot = 2'd1; load_addr = 10'h3FF;
        tick();
        load_slot = 2'd3; load_addr = 10'h0AB;
        tick();
        load_en = 1'b0;
        check("load_during_run_valid", {28'd0, slot_valid}, 32'hA);
        for (int i = 0; i < 12; i++) tick();
        check("run3_still_running", {31'd0, hlt}, 32'd0);
        proc_end = 1'b1; syscall = 1'b1; proc_pc = 10'h0F0;
        tick();
        proc_end = 1'b0; syscall = 1'b0;
        check("save3_hlt", {31'd0, hlt}, 32'd1);
        check("save3_cause_end", {30'd0, cause}, 32'd3);
        tick();
        check("ret3_irq", {31'd0, irq_os}, 32'd1);
        check("ret3_valid_cleared", {28'd0, slot_valid}, 32'h8);
        tick();
        os_dispatch = 1'b1; disp_slot = 2'd1;
        tick();
        os_dispatch = 1'b0;
        check_idle("ended_disp");
        tick();
        check_idle("ended_disp2");

        // Simultaneous load and dispatch of slot 0: RESTORE sees the new address.
        load_en = 1'b1; load_slot = 2'd0; load_addr = 10'h155;
        os_dispatch = 1'b1; disp_slot = 2'd0;
        tick();
        load_en = 1'b0; os_dispatch = 1'b0;
        check("ld_disp_ovr_addr", {22'd0, pc_ovr_addr}, 32'h155);
        check("ld_disp_cur_slot", {30'd0, cur_slot}, 32'd0);
        check("ld_disp_valid", {28'd0, slot_valid}, 32'h9);
        tick();
        syscall = 1'b1;
        tick();
        syscall = 1'b0;
        check("save4_cause", {30'd0, cause}, 32'd2);
        tick(); tick();

        // Slot 3 restores its loaded PC; reset asserted during SAVE.
        os_dispatch = 1'b1; disp_slot = 2'd3;
        tick();
        os_dispatch = 1'b0;
        check("restore5_ovr_addr", {22'd0, pc_ovr_addr}, 32'h0AB);
        tick();
        syscall = 1'b1;
        tick();
        syscall = 1'b0;
        check("save5_hlt", {31'd0, hlt}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("rst_save");
        check("rst_save_valid", {28'd0, slot_valid}, 32'h0);
        check("rst_save_cause", {30'd0, cause}, 32'd0);
        check("rst_save_cur_slot", {30'd0, cur_slot}, 32'd0);
        tick();
        check_idle("rst_save_no_irq");
        os_dispatch = 1'b1; disp_slot = 2'd3;
        tick();
        os_dispatch = 1'b0;
        check_idle("rst_disp_ignored");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/context_ctrl.md
# context_ctrl

Process context-switch controller that drives the two-context program counter (OS PC / process PC) from the scheduling side. It holds a small table of saved process PCs and decides when control passes between the OS and a process: on dispatch, quantum expiry, syscall or process end. It sits between the OS-visible control registers and the PC block. It drives `proc_num`, `hlt` and a PC-override path, and reads back the process-only PC on preemption.

## Interface
- `NPROC`, 4: number of process slots; power of two, at least 2.
- `QUANTUM`, 16: process run length in cycles before preemption; at least 2.
- `ADDR_W`, 10: PC width.
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `load_en` input 1: write `load_addr` into slot `load_slot` and set that slot valid.
- `load_slot` input log2(NPROC): slot index for the load.
- `load_addr` input ADDR_W: initial PC of the slot.
- `os_dispatch` input 1: pulse from the OS requesting a run of slot `disp_slot`.
- `disp_slot` input log2(NPROC): slot to dispatch.
- `syscall` input 1: trap from the running process.
- `proc_end` input 1: running process terminates.
- `proc_pc` input ADDR_W: current process PC, taken from the PC block's process-only output.
- `proc_num` output 1: 0 = OS context, 1 = process context.
- `hlt` output 1: freezes the PC block.
- `pc_ovr_en` output 1: when high, the PC input mux selects `pc_ovr_addr`.
- `pc_ovr_addr` output ADDR_W: PC value to restore.
- `cur_slot` output log2(NPROC): slot that is running or was last run.
- `cause` output 2: 0 none, 1 quantum, 2 syscall, 3 end; held until the next dispatch.
- `irq_os` output 1: one-cycle pulse on return to the OS.
- `slot_valid` output NPROC: per-slot valid flags.

## Operation
- States: `OS_RUN`, `RESTORE`, `PROC_RUN`, `SAVE`, `RETURN`.
- `OS_RUN`
  - Outputs: `proc_num`=0, `hlt`=0, `pc_ovr_en`=0.
  - When `os_dispatch` is high and `slot_valid[disp_slot]` is set: latch `cur_slot`, clear `cause`, go to `RESTORE`.
  - A dispatch to an invalid slot is ignored; no state change.
- `RESTORE` (one cycle)
  - Outputs: `proc_num`=1, `pc_ovr_en`=1, `pc_ovr_addr`=table[`cur_slot`].
  - Quantum counter loads `QUANTUM-1`. Go to `PROC_RUN`.
- `PROC_RUN`
  - Outputs: `proc_num`=1, override off. Counter decrements every cycle.
  - Exit to `SAVE` when `proc_end`, `syscall`, or counter==0 is seen.
  - Priority for `cause`: end (3) > syscall (2) > quantum (1).
- `SAVE` (one cycle)
  - Outputs: `hlt`=1, `proc_num`=1.
  - table[`cur_slot`] <= `proc_pc`.
  - If cause is end: clear `slot_valid[cur_slot]`; the table entry is still written.
  - Go to `RETURN`.
- `RETURN` (one cycle)
  - Outputs: `proc_num`=0, `hlt`=0, `irq_os`=1. Go to `OS_RUN`.
- `load_en`
  - Accepted in any state, except when `load_slot`==`cur_slot` while in `RESTORE`, `PROC_RUN` or `SAVE`; that case is ignored.
  - In `OS_RUN`, simultaneous `load_en` and `os_dispatch` to the same slot: the load happens first, and `RESTORE` uses the new address.
- `syscall` and `proc_end` are ignored outside `PROC_RUN`.
- `os_dispatch` is ignored outside `OS_RUN`.
- Reset values: state `OS_RUN`; all outputs 0; `slot_valid`=0; table entries 0; counter 0.
  - Reset overrides every other input in the same cycle, including mid-`PROC_RUN` and mid-`SAVE`.

## Timing
- Dispatch sampled at edge N: `RESTORE` during cycle N+1. The PC block loads the override at edge N+2. The process executes from cycle N+2.
- Quantum: exactly `QUANTUM` cycles in `PROC_RUN` when there is no trap. `SAVE` follows, then `RETURN`; the OS context resumes the cycle after `RETURN`.
- Trap asserted in `PROC_RUN` at edge M: `SAVE` in cycle M+1, `irq_os` in cycle M+2.
- A trap on the same cycle the counter hits 0 reports the trap's cause, not quantum.
- Saved PC is `proc_pc` as sampled during `SAVE`, while `hlt` holds it stable.

## Structure
- Shared package holds:
  - the state enum;
  - cause codes `CAUSE_NONE/QUANTUM/SYSCALL/END`;
  - `ADDR_W`.
- One sub-module, `ctx_table`: `NPROC`×`ADDR_W` register file with one write port (load/save arbitration inside `context_ctrl`), one combinational read port, and synchronous reset to 0.
- FSM, quantum counter and valid flags live in `context_ctrl`.

## Test plan
- Reset, then load slot 1 = 0x040 and dispatch slot 1 -> `RESTORE` drives `pc_ovr_addr`=0x040 and `proc_num`=1. After `QUANTUM`=16 cycles, `cause`=1, `irq_os` pulses, table[1]=`proc_pc`.
- Dispatch slot 2 while `slot_valid[2]`=0 -> no state change, `proc_num` stays 0, no `irq_os`.
- `syscall` 3 cycles into `PROC_RUN` with `proc_pc`=0x123 -> `cause`=2, table[slot]=0x123. A redispatch restores 0x123.
- `proc_end` and `syscall` together on the counter==0 cycle -> `cause`=3, `slot_valid` bit cleared, a later dispatch of that slot is ignored.
- `load_en` to `cur_slot` during `PROC_RUN` -> ignored. `load_en` to another slot -> written and valid.
- `reset` asserted during `SAVE` -> next cycle state `OS_RUN`, all outputs 0, `slot_valid`=0.
